// File: rtl/char_reg_pkg.sv
// Shared constants, state encoding and checksum helper for the image byte-stream writer.
package char_reg_pkg;

  localparam int          IMG_W     = 28;
  localparam int          IMG_H     = 28;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int          ADDR_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_UNPACK = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  function automatic int num_bytes(input int npix);
    return (npix + 7) / 8;
  endfunction

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/px_unpack.sv
// Byte-to-pixel unpacker: holds one payload byte and presents its bits MSB first.
module px_unpack (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       msb,
  output logic       last
);

  logic [7:0] sr_r;
  logic [2:0] cnt_r;

  // Shift register and bit counter; a load restarts the bit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r  <= 8'h00;
      cnt_r <= 3'd0;
    end else if (load) begin
      sr_r  <= din;
      cnt_r <= 3'd0;
    end else if (shift) begin
      sr_r  <= {sr_r[6:0], 1'b0};
      cnt_r <= cnt_r + 3'd1;
    end
  end

  assign msb  = sr_r[7];
  assign last = (cnt_r == 3'd7);

endmodule

// File: rtl/img_writer.sv
// Receives a sync-framed, XOR-checksummed byte stream and writes it as 1-bit pixels
// into the image RAM, then starts the recognizer when the checksum matches.
module img_writer #(
  parameter int         IMG_W     = char_reg_pkg::IMG_W,
  parameter int         IMG_H     = char_reg_pkg::IMG_H,
  parameter logic [7:0] SYNC_BYTE = char_reg_pkg::SYNC_BYTE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           in_ready,
  input  logic                           rec_busy,
  output logic                           wr_en,
  output logic [char_reg_pkg::ADDR_W-1:0] wr_addr,
  output logic                           wr_data,
  output logic                           frame_start,
  output logic                           frame_err
);
  import char_reg_pkg::*;

  localparam int                NPIX      = IMG_W * IMG_H;
  localparam int                NB        = num_bytes(NPIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [7:0]        NB_CNT    = 8'(NB);

  state_t              state_r, state_s;
  logic                in_ready_s, accept_s;
  logic                init_s, load_s, shift_s, ok_s, bad_s;
  logic                msb_s, last_s, unpack_done_s;
  logic [7:0]          byte_cnt_r, csum_r;
  logic [ADDR_W-1:0]   addr_r, wr_addr_r;
  logic                wr_en_r, wr_data_r, frame_start_r, frame_err_r;

  px_unpack u_unpack (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .din   (in_data),
    .msb   (msb_s),
    .last  (last_s)
  );

  assign accept_s      = in_valid && in_ready_s;
  // The last pixel ends a byte early when the final byte carries padding bits.
  assign unpack_done_s = last_s || (addr_r == LAST_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (accept_s && (in_data == SYNC_BYTE)) state_s = ST_RECV; else state_s = ST_IDLE;
      ST_RECV:   if (accept_s) state_s = ST_UNPACK; else state_s = ST_RECV;
      ST_UNPACK: if (unpack_done_s) state_s = (byte_cnt_r == NB_CNT) ? ST_CHECK : ST_RECV;
                 else state_s = ST_UNPACK;
      ST_CHECK:  if (accept_s) state_s = ST_IDLE; else state_s = ST_CHECK;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Handshake and datapath strobes; ready is held low while in reset.
  always_comb begin
    in_ready_s = 1'b0;
    init_s     = 1'b0;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    ok_s       = 1'b0;
    bad_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = !rec_busy && !rst;
        init_s     = accept_s && (in_data == SYNC_BYTE);
      end
      ST_RECV: begin
        in_ready_s = !rst;
        load_s     = accept_s;
      end
      ST_UNPACK: shift_s = 1'b1;
      ST_CHECK: begin
        in_ready_s = !rst;
        ok_s       = accept_s && (in_data == csum_r);
        bad_s      = accept_s && (in_data != csum_r);
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  // Byte count, checksum, pixel address and registered RAM/pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_r    <= 8'd0;
      csum_r        <= 8'h00;
      addr_r        <= '0;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= '0;
      wr_data_r     <= 1'b0;
      frame_start_r <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      wr_en_r       <= shift_s;
      frame_start_r <= ok_s;
      frame_err_r   <= bad_s;
      if (init_s) begin
        byte_cnt_r <= 8'd0;
        csum_r     <= 8'h00;
        addr_r     <= '0;
      end else if (load_s) begin
        byte_cnt_r <= byte_cnt_r + 8'd1;
        csum_r     <= csum_next(csum_r, in_data);
      end else if (shift_s) begin
        addr_r    <= addr_r + ADDR_W'(1);
        wr_addr_r <= addr_r;
        wr_data_r <= msb_s;
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign wr_en       = wr_en_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign frame_start = frame_start_r;
  assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_img_writer.sv
// Directed bench for img_writer: a frame table plus hand sequences for busy gating and reset.
module tb_img_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       rec_busy = 1'b0;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic       wr_data;
  logic       frame_start;
  logic       frame_err;

  img_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rec_busy(rec_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nfail = 0;
  int   wr_total = 0, oob = 0, starts = 0, errs = 0, both = 0;
  int   hits [0:1023];
  int   hits0 [0:1023];
  logic mem [0:1023];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      hits[i] = 0;
      mem[i]  = 1'b0;
    end
  end

  // Write/pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_total++;
      if (wr_addr > 10'd783) oob++;
      else begin
        hits[wr_addr]++;
        mem[wr_addr] = wr_data;
      end
    end
    if (frame_start) starts++;
    if (frame_err) errs++;
    if (frame_start && frame_err) both++;
  end

  typedef struct {
    logic       prefix;
    logic [7:0] first;
    logic [7:0] fill;
    logic [7:0] csum;
    logic       gap;
    int         exp_start;
    int         exp_err;
    logic [7:0] exp_px0;
    logic       exp_last;
  } vec_t;

  vec_t vecs [0:6];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input logic gap);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nvec++;
      nfail++;
      $display("FAIL handshake_timeout: byte %h not accepted in 50 cycles, expected acceptance", b);
    end
    @(posedge clk);
    @(negedge clk);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int s0, e0, w0, o0, bad, px0;
    s0 = starts; e0 = errs; w0 = wr_total; o0 = oob;
    for (int i = 0; i < 1024; i++) hits0[i] = hits[i];
    if (v.prefix) begin
      send_byte(8'h00, v.gap);
      send_byte(8'h3C, v.gap);
    end
    send_byte(8'hA5, v.gap);
    send_byte(v.first, v.gap);
    for (int i = 1; i < 98; i++) send_byte(v.fill, v.gap);
    send_byte(v.csum, 1'b0);
    check($sformatf("v%0d_start_pulse", k), int'(frame_start), v.exp_start);
    check($sformatf("v%0d_err_pulse", k), int'(frame_err), v.exp_err);
    idle(4);
    check($sformatf("v%0d_writes", k), wr_total - w0, 784);
    check($sformatf("v%0d_oob_writes", k), oob - o0, 0);
    bad = 0;
    for (int i = 0; i < 784; i++) if (hits[i] - hits0[i] != 1) bad++;
    check($sformatf("v%0d_addr_coverage_errors", k), bad, 0);
    check($sformatf("v%0d_starts", k), starts - s0, v.exp_start);
    check($sformatf("v%0d_errs", k), errs - e0, v.exp_err);
    px0 = 0;
    for (int i = 0; i < 8; i++) px0 = (px0 << 1) | int'(mem[i]);
    check($sformatf("v%0d_px0_7", k), px0, int'(v.exp_px0));
    check($sformatf("v%0d_px783", k), int'(mem[783]), int'(v.exp_last));
    check($sformatf("v%0d_back_to_idle_ready", k), int'(in_ready), 1);
  endtask

  initial begin
    int s0, e0, busy_ready;
    //          prefix first  fill   csum   gap  start err  px0    last
    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1, 0, 8'hFF, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 1'b0, 0, 1, 8'hFF, 1'b1};
    vecs[2] = '{1'b1, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1, 0, 8'hA5, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1, 0, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 1'b1, 1, 0, 8'hFF, 1'b1};
    vecs[5] = '{1'b0, 8'h3C, 8'h5A, 8'h66, 1'b0, 1, 0, 8'h3C, 1'b0};
    vecs[6] = '{1'b0, 8'h3C, 8'h5A, 8'h00, 1'b0, 0, 1, 8'h3C, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_pulses", int'(frame_start) + int'(frame_err), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Recognizer busy holds off the sync byte until it drops.
    rec_busy   = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'hA5;
    busy_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      busy_ready += int'(in_ready);
    end
    check("busy_ready_cycles", busy_ready, 0);
    s0 = starts;
    rec_busy = 1'b0;
    #1;
    check("busy_release_ready", int'(in_ready), 1);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 98; i++) send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    idle(3);
    check("busy_frame_starts", starts - s0, 1);

    // Reset in the middle of a frame, then a clean frame.
    s0 = starts; e0 = errs;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 40; i++) send_byte(8'hFF, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_wr_en", int'(wr_en), 0);
    check("midrst_wr_addr", int'(wr_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(7, vecs[0]);
    check("midrst_total_starts", starts - s0, 1);
    check("midrst_total_errs", errs - e0, 0);

    check("start_err_overlap", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
